disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl_pkg.sv | 24 ++
 rtl/disp_scan_ctrl_if.sv | 19 +
 rtl/disp_scan_ctrl_seg_hex_decode.sv | 33 +++
 rtl/disp_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// disp_scan_ctrl_pkg
//   Definitions shared by the display scan controller files: the scan FSM
//   state encoding, the register addresses and the CTRL bit positions.
//   There are no ports; each file pulls it in with an import.
package disp_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  // Register map
  localparam logic [1:0] ADDR_PEND   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL fields
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MASK_LSB = 1;
  localparam int CTRL_MASK_MSB = 4;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if
//   Register bus for the display scan controller.
//   Signals:
//     wr_en   - one-cycle write strobe
//     addr    - register index, used for both writes and reads
//     wr_data - write data
//     rd_data - read data for addr
//   Handshake: there is no ready and no acknowledge. A write is accepted
//   on every clock edge where wr_en is high. rd_data is combinational from
//   addr and is valid in the same cycle.
interface disp_scan_ctrl_if;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  modport master (output wr_en, output addr, output wr_data, input rd_data);
  modport slave  (input wr_en, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/disp_scan_ctrl_seg_hex_decode.sv
// seg_hex_decode
//   Converts a hex digit into the pattern for an active-low seven-segment
//   display. The decimal point is always off.
//   Ports:
//     nibble - input,  4 bits: hex digit
//     seg    - output, 8 bits: bit7=a .. bit1=g, bit0=dp (active-low)
module seg_hex_decode (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  always_comb begin
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      4'hF: seg = 8'h71;
      default: seg = 8'hFF;
    endcase
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scans a 4-digit multiplexed seven-segment display. Each digit gets a
//   slot of CLK_DIV cycles. The slot is shown for CLK_DIV-BLANK_CYC cycles
//   and then blanked for BLANK_CYC cycles. Software writes the digits into
//   PEND. PEND is copied into ACTIVE at every frame start, so a frame
//   never shows a mix of old and new digits.
//   Ports:
//     clk, rst_n - clock; asynchronous active-low reset
//     bus        - register bus (slave modport)
//     seg        - active-low segments, bit7=a .. bit1=g, bit0=dp
//     an         - active-low digit selects, bit i = digit i
//     dbg_state  - current scan FSM state
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  disp_scan_ctrl_if.slave   bus,
  output logic [7:0]        seg,
  output logic [3:0]        an,
  output state_e            dbg_state
);
  localparam int CNT_W    = $clog2(CLK_DIV);
  localparam int SHOW_LEN = CLK_DIV - BLANK_CYC;

  logic [15:0]      pend;
  logic [15:0]      active;
  logic             ctrl_en;
  logic [3:0]       mask;
  state_e           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic pend_wr;
  logic ctrl_wr;
  logic disable_wr;

  assign pend_wr    = bus.wr_en && (bus.addr == ADDR_PEND);
  assign ctrl_wr    = bus.wr_en && (bus.addr == ADDR_CTRL);
  // A write that clears enable stops the scan on the write edge itself.
  // This blanks the outputs in the cycle right after the write.
  assign disable_wr = ctrl_wr && !bus.wr_data[CTRL_EN_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      ctrl_en <= 1'b0;
      mask    <= '0;
    end else begin
      if (pend_wr) pend <= bus.wr_data;
      if (ctrl_wr) begin
        ctrl_en <= bus.wr_data[CTRL_EN_BIT];
        mask    <= bus.wr_data[CTRL_MASK_MSB:CTRL_MASK_LSB];
      end
    end
  end

  // ACTIVE loads from the registered PEND. A PEND write on the same edge
  // as a load is therefore seen only at the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      active <= '0;
    end else if (!ctrl_en || disable_wr) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= SHOW;
          idx    <= '0;
          cnt    <= '0;
          active <= pend;
        end
        SHOW: begin
          if (cnt == CNT_W'(SHOW_LEN - 1)) begin
            state <= BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYC - 1)) begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == 2'd3) active <= pend;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:0] nibble;
  logic [7:0] dec_seg;
  logic       digit_on;

  assign nibble = active[{idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // The blank mask is read live from CTRL, so a mask change takes effect
  // right away. The digit value changes only at a frame load.
  assign digit_on  = (state == SHOW) && !mask[idx];
  assign an        = digit_on ? ~(4'b0001 << idx) : 4'b1111;
  assign seg       = digit_on ? dec_seg : 8'hFF;
  assign dbg_state = state;

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      ADDR_PEND:   bus.rd_data = pend;
      ADDR_CTRL:   bus.rd_data = {11'd0, mask, ctrl_en};
      ADDR_STATUS: bus.rd_data = {13'd0, (state == SHOW), idx};
      ADDR_RSVD:   bus.rd_data = '0;
      default:     bus.rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
//   Directed bench for disp_scan_ctrl with CLK_DIV=8 and BLANK_CYC=2.
//   A slot is 6 SHOW cycles plus 2 BLANK cycles, and a frame is 32 cycles.
module tb_disp_scan_ctrl;
  import disp_scan_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] seg;
  logic [3:0] an;
  state_e     dbg_state;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .seg       (seg),
    .an        (an),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];   // {an, seg} expected per cycle
  logic [7:0]  hex_tbl[16];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    bus.addr = a;
    #1;
    v = bus.rd_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Pushes one frame of expected outputs for digits p and blank mask m.
  task automatic push_frame(input logic [15:0] p, input logic [3:0] m);
    logic [3:0] nib;
    logic [3:0] an_e;
    for (int d = 0; d < 4; d++) begin
      nib  = p[d*4 +: 4];
      an_e = 4'b1111 ^ (4'b0001 << d);
      for (int c = 0; c < 6; c++)
        exp_q.push_back(m[d] ? {4'hF, 8'hFF} : {an_e, hex_tbl[nib]});
      for (int c = 0; c < 2; c++) exp_q.push_back({4'hF, 8'hFF});
    end
  endtask

  task automatic step_chk(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) check({tag, "_qempty"}, 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check(tag, {20'd0, an, seg}, {20'd0, e});
    end
    tick();
  endtask

  task automatic step_n(input int n, input string tag);
    for (int i = 0; i < n; i++) step_chk(tag);
  endtask

  task automatic wr_step(input logic [1:0] a, input logic [15:0] d, input string tag);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    step_chk(tag);
    bus.wr_en   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] v;

  initial begin
    hex_tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = 2'd0;
    bus.wr_data = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rd(ADDR_PEND, v);   check("rst_pend", {16'd0, v}, 32'h0);
    rd(ADDR_STATUS, v); check("rst_status", {16'd0, v}, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_hold", 32'(dbg_state), 32'(IDLE));

    // Basic scan
    wr(ADDR_PEND, 16'h4321);
    wr(ADDR_CTRL, 16'h0001);
    rd(ADDR_PEND, v); check("rd_pend", {16'd0, v}, 32'h4321);
    rd(ADDR_CTRL, v); check("rd_ctrl", {16'd0, v}, 32'h1);
    check("pre_show_an", {28'd0, an}, 32'hF);
    tick();
    check("show_state", 32'(dbg_state), 32'(SHOW));
    rd(ADDR_STATUS, v); check("status_show0", {16'd0, v}, 32'h4);
    rd(ADDR_RSVD, v);   check("rd_rsvd", {16'd0, v}, 32'h0);
    push_frame(16'h4321, 4'h0);
    step_n(32, "f0");

    // Mid-frame PEND write
    push_frame(16'h4321, 4'h0);
    step_n(8, "f1");
    wr_step(ADDR_PEND, 16'hFFFF, "f1_wr");
    step_n(23, "f1");
    push_frame(16'hFFFF, 4'h0);
    step_n(32, "f2");

    // PEND write on the exact wrap edge
    push_frame(16'hFFFF, 4'h0);
    step_n(31, "f3");
    wr_step(ADDR_PEND, 16'h8765, "f3_wrap");
    push_frame(16'hFFFF, 4'h0);
    step_n(32, "f4_old");
    push_frame(16'h8765, 4'h0);
    step_n(31, "f5_new");
    wr_step(ADDR_CTRL, 16'h0005, "f5_mask");

    // Digit 1 masked
    rd(ADDR_CTRL, v); check("rd_ctrl_mask", {16'd0, v}, 32'h5);
    push_frame(16'h8765, 4'h2);
    step_n(32, "f6_mask");

    // Disable during SHOW, then restart
    push_frame(16'h8765, 4'h2);
    step_n(3, "f7");
    wr_step(ADDR_CTRL, 16'h0000, "f7_dis");
    exp_q.delete();
    check("dis_an", {28'd0, an}, 32'hF);
    check("dis_seg", {24'd0, seg}, 32'hFF);
    check("dis_state", 32'(dbg_state), 32'(IDLE));
    rd(ADDR_STATUS, v); check("dis_status", {16'd0, v}, 32'h0);
    wr(ADDR_PEND, 16'hABCD);
    wr(ADDR_CTRL, 16'h0001);
    check("re_pre_an", {28'd0, an}, 32'hF);
    tick();
    rd(ADDR_STATUS, v); check("re_status", {16'd0, v}, 32'h4);
    push_frame(16'hABCD, 4'h0);
    step_n(32, "f8");

    // Asynchronous reset mid-SHOW
    push_frame(16'hABCD, 4'h0);
    step_n(3, "f9");
    check("pre_rst_an", {28'd0, an}, 32'hE);
    rst_n = 1'b0;
    #1;
    check("arst_an", {28'd0, an}, 32'hF);
    check("arst_seg", {24'd0, seg}, 32'hFF);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("arst_reg%0d", a), {16'd0, v}, 32'h0);
    end
    repeat (5) tick();
    check("post_rst_idle", 32'(dbg_state), 32'(IDLE));
    check("post_rst_an", {28'd0, an}, 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
